// File: rtl/panel_msg_scheduler.sv
// Round-robin scheduler that shares the 13-character text panel between three message sources.
// A granted message is committed only on a frame boundary, held for a minimum number of frames,
// and replaced by a default banner after a period with no requests.
module panel_msg_scheduler #(
    parameter int unsigned  HOLD_FRAMES = 30,
    parameter int unsigned  IDLE_FRAMES = 120,
    parameter logic [103:0] IDLE_STRING = "ORGAN READY  "
) (
    input  logic         vga_clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic [2:0]   req,
    input  logic [103:0] msg_0,
    input  logic [103:0] msg_1,
    input  logic [103:0] msg_2,
    output logic [2:0]   ack,
    output logic [103:0] panel_string,
    output logic [1:0]   owner,
    output logic         busy,
    output logic         update
);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, HOLD} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic       IDLE_EN   = (IDLE_FRAMES != 0);
    localparam logic [7:0] IDLE_LAST = (IDLE_FRAMES == 0) ? 8'd0 : 8'(IDLE_FRAMES - 1);

    state_t       state;
    logic [103:0] pend;
    logic [1:0]   pend_id;
    logic [1:0]   rr;
    logic [7:0]   hold_cnt;
    logic [7:0]   idle_cnt;

    logic [1:0]   grant_id;
    logic         grant_any;
    logic [1:0]   scan;
    logic [103:0] grant_msg;

    // Cyclic scan of req starting at the round-robin pointer; first set bit wins.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        scan      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            scan = 2'((32'(rr) + k) % 3);
            if (!grant_any && req[scan]) begin
                grant_any = 1'b1;
                grant_id  = scan;
            end
        end
    end

    always_comb begin
        grant_msg = msg_2;
        case (grant_id)
            2'd0:    grant_msg = msg_0;
            2'd1:    grant_msg = msg_1;
            default: grant_msg = msg_2;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state        <= IDLE;
            panel_string <= IDLE_STRING;
            owner        <= 2'd3;
            ack          <= '0;
            update       <= 1'b0;
            rr           <= '0;
            hold_cnt     <= '0;
            idle_cnt     <= '0;
            pend         <= '0;
            pend_id      <= '0;
        end else begin
            ack    <= '0;
            update <= 1'b0;
            case (state)
                IDLE: begin
                    // A grant takes priority over any frame_start in the same cycle.
                    if (grant_any) begin
                        pend            <= grant_msg;
                        pend_id         <= grant_id;
                        ack[grant_id]   <= 1'b1;
                        rr              <= (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
                        idle_cnt        <= '0;
                        state           <= WAIT_FRAME;
                    end else if (frame_start) begin
                        if (IDLE_EN && idle_cnt == IDLE_LAST && owner != 2'd3) begin
                            panel_string <= IDLE_STRING;
                            owner        <= 2'd3;
                            update       <= 1'b1;
                            idle_cnt     <= '0;
                        end else if (idle_cnt != 8'hFF) begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        panel_string <= pend;
                        owner        <= pend_id;
                        update       <= 1'b1;
                        hold_cnt     <= HOLD_INIT;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_start) begin
                        hold_cnt <= hold_cnt - 8'd1;
                        if (hold_cnt == 8'd1) begin
                            idle_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_msg_scheduler.sv
// Scoreboard bench for panel_msg_scheduler: stimulus pushes expected acks and commits,
// a negedge monitor pops and compares whenever the DUT pulses ack or update.
module tb_panel_msg_scheduler;

    localparam logic [103:0] BANNER = "ORGAN READY  ";
    localparam logic [103:0] C4     = "C4 VOL 08    ";
    localparam logic [103:0] R0     = "RR SRC 0     ";
    localparam logic [103:0] R1     = "RR SRC 1     ";
    localparam logic [103:0] R2     = "RR SRC 2     ";
    localparam logic [103:0] S1A    = "S1 FIRST     ";
    localparam logic [103:0] S1B    = "S1 SECOND    ";
    localparam logic [103:0] D5     = "D5 VOL 12    ";
    localparam logic [103:0] A4     = "A4 VOL 10    ";

    typedef struct packed {
        logic [103:0] s;
        logic [1:0]   o;
    } upd_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic [2:0]   req;
    logic [103:0] msg_0, msg_1, msg_2;
    logic [2:0]   ack, ack_z;
    logic [103:0] panel_string, str_z;
    logic [1:0]   owner, owner_z;
    logic         busy, busy_z;
    logic         update, upd_z;

    int tests = 0;
    int fails = 0;
    int frame_no = 0;
    int upd_count = 0;
    int upd_frame [0:63];
    int z_acks = 0;
    int ack_pushes = 0;
    int base;

    logic [2:0] exp_ack [$];
    upd_t       exp_upd [$];

    always #5 clk = ~clk;

    panel_msg_scheduler #(.HOLD_FRAMES(2), .IDLE_FRAMES(4)) dut (
        .vga_clk(clk), .rst(rst), .frame_start(frame_start), .req(req),
        .msg_0(msg_0), .msg_1(msg_1), .msg_2(msg_2),
        .ack(ack), .panel_string(panel_string), .owner(owner), .busy(busy), .update(update)
    );

    panel_msg_scheduler #(.HOLD_FRAMES(2), .IDLE_FRAMES(0)) dut_z (
        .vga_clk(clk), .rst(rst), .frame_start(frame_start), .req(req),
        .msg_0(msg_0), .msg_1(msg_1), .msg_2(msg_2),
        .ack(ack_z), .panel_string(str_z), .owner(owner_z), .busy(busy_z), .update(upd_z)
    );

    task automatic chk(input string name, input logic [103:0] got, input logic [103:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_no++;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic push_ack(input logic [2:0] a);
        exp_ack.push_back(a);
        ack_pushes++;
    endtask

    task automatic push_upd(input logic [103:0] s, input logic [1:0] o);
        upd_t u;
        u.s = s;
        u.o = o;
        exp_upd.push_back(u);
    endtask

    always @(negedge clk) begin
        upd_t u;
        if (ack != 3'b000) begin
            if (exp_ack.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got %b, expected none", ack);
            end else begin
                chk("ack", 104'(ack), 104'(exp_ack.pop_front()));
            end
        end
        if (update) begin
            if (upd_count < 64) upd_frame[upd_count] = frame_no;
            upd_count++;
            if (exp_upd.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_update: got owner %0d string %h, expected none", owner, panel_string);
            end else begin
                u = exp_upd.pop_front();
                chk("commit_string", panel_string, u.s);
                chk("commit_owner", 104'(owner), 104'(u.o));
            end
        end
        if (ack_z != 3'b000) z_acks++;
        if (upd_z && owner_z == 2'd3) begin
            tests++;
            fails++;
            $display("FAIL zero_idle_banner: got owner %0d, expected no banner load", owner_z);
        end
    end

    initial begin
        rst = 1'b1; req = '0; frame_start = 1'b0;
        msg_0 = '0; msg_1 = '0; msg_2 = '0;
        cyc(); cyc();
        chk("rst_string", panel_string, BANNER);
        chk("rst_owner", 104'(owner), 104'(3));
        chk("rst_ack", 104'(ack), 104'(0));
        chk("rst_busy", 104'(busy), 104'(0));
        chk("rst_update", 104'(update), 104'(0));
        rst = 1'b0;

        // single request
        msg_0 = C4; req = 3'b001; push_ack(3'b001);
        cyc();
        chk("grant_busy", 104'(busy), 104'(1));
        req = '0;
        cyc(); cyc();
        chk("no_early_commit", panel_string, BANNER);
        push_upd(C4, 2'd0);
        pulse_frame();
        chk("single_string", panel_string, C4);
        chk("single_owner", 104'(owner), 104'(0));
        pulse_frame();
        chk("hold_busy", 104'(busy), 104'(1));
        pulse_frame();
        chk("hold_exit", 104'(busy), 104'(0));

        // round robin from a fresh pointer
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        msg_0 = R0; msg_1 = R1; msg_2 = R2; req = 3'b111;
        push_ack(3'b001); push_ack(3'b010); push_ack(3'b100); push_ack(3'b001);
        push_upd(R0, 2'd0); push_upd(R1, 2'd1); push_upd(R2, 2'd2); push_upd(R0, 2'd0);
        base = upd_count;
        cyc();
        for (int i = 0; i < 12; i++) begin
            pulse_frame();
            if (upd_count - base == 4) req = '0;
        end
        chk("rr_count", 104'(upd_count - base), 104'(4));
        for (int i = 0; i < 3; i++)
            chk("rr_spacing", 104'(upd_frame[base + i + 1] - upd_frame[base + i]), 104'(3));
        chk("rr_idle", 104'(busy), 104'(0));

        // grant beats a coincident frame_start that would otherwise load the banner
        repeat (3) pulse_frame();
        chk("pre_sim_owner", 104'(owner), 104'(0));
        msg_1 = S1A; req = 3'b010; push_ack(3'b010); push_upd(S1A, 2'd1);
        frame_no++;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0; msg_1 = S1B; req = '0;
        cyc(); cyc();
        chk("sim_no_banner", 104'(owner), 104'(0));
        chk("sim_busy", 104'(busy), 104'(1));
        pulse_frame();
        chk("sim_sampled_msg", panel_string, S1A);
        repeat (2) pulse_frame();

        // idle timeout after a source-2 message
        msg_2 = D5; req = 3'b100; push_ack(3'b100); push_upd(D5, 2'd2);
        cyc();
        req = '0;
        cyc();
        repeat (3) pulse_frame();
        repeat (3) pulse_frame();
        chk("idle_pre_owner", 104'(owner), 104'(2));
        base = upd_count;
        push_upd(BANNER, 2'd3);
        pulse_frame();
        chk("idle_banner_owner", 104'(owner), 104'(3));
        chk("idle_banner_once", 104'(upd_count - base), 104'(1));
        base = upd_count;
        repeat (10) pulse_frame();
        chk("idle_quiet", 104'(upd_count - base), 104'(0));
        chk("zero_idle_owner", 104'(owner_z), 104'(2));
        chk("zero_idle_string", str_z, D5);

        // reset while a message waits for its frame
        msg_0 = A4; req = 3'b001; push_ack(3'b001);
        cyc();
        req = '0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", 104'(busy), 104'(0));
        chk("midrst_string", panel_string, BANNER);
        chk("midrst_owner", 104'(owner), 104'(3));
        req = 3'b100; push_ack(3'b100);
        cyc();
        chk("post_rst_ack", 104'(ack), 104'(3'b100));
        req = '0;
        push_upd(D5, 2'd2);
        pulse_frame();
        chk("post_rst_commit", panel_string, D5);
        repeat (2) pulse_frame();
        chk("post_rst_idle", 104'(busy_z), 104'(0));

        chk("ack_queue_empty", 104'(exp_ack.size()), 104'(0));
        chk("upd_queue_empty", 104'(exp_upd.size()), 104'(0));
        chk("zero_idle_acks", 104'(z_acks), 104'(ack_pushes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/panel_msg_scheduler.md
# panel_msg_scheduler

Sequences and shares the 13-character text panel between three message sources: keyboard note readout, mode/menu status and playback status. Arbitrates round-robin between requesters and latches the winning message. Commits it to the panel string only on a frame boundary, so no frame shows a torn string. Holds each message for a minimum number of frames, and reverts to a default banner after a period with no requests. Its `string` output drives the 104-bit string input of the VGA text panel.

## Interface
- `HOLD_FRAMES`, 30: frames a committed requester message is held before new grants; legal range 1..255.
- `IDLE_FRAMES`, 120: frames in IDLE before the banner is restored; 0 disables; max 255.
- `IDLE_STRING`, ASCII "ORGAN READY  " (13 chars, char 0 in bits [103:96]): banner and reset string.
- `vga_clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse per frame, at start of vertical blank.
- `req` in 3: request per source; bit i is held high with `msg_i` stable until `ack[i]` is seen.
- `msg_0`, `msg_1`, `msg_2` in 104 each: message per source; char 0 in bits [103:96].
- `ack` out 3: one-cycle capture acknowledge, one-hot or zero.
- `string` out 104: current panel string.
- `owner` out 2: source of `string`; 0–2 = requester, 3 = banner.
- `busy` out 1: high when state ≠ IDLE.
- `update` out 1: one-cycle pulse in the cycle `string` takes a new value.

## Operation
- State machine: IDLE, WAIT_FRAME, HOLD. Registers:
  - `pend` (104 b)
  - `pend_id` (2 b)
  - `rr` round-robin pointer (2 b, values 0–2)
  - `hold_cnt` (8 b)
  - `idle_cnt` (8 b)
- Arbitration in IDLE: scan `req` cyclically starting at index `rr`; the first set bit g wins.
- IDLE with any `req` set, at the edge:
  - `pend`←`msg_g`, `pend_id`←g, `ack[g]`←1 for one cycle.
  - `rr`←(g+1) mod 3, `idle_cnt`←0, go to WAIT_FRAME.
- WAIT_FRAME: `req` is ignored and no ack is issued. On `frame_start`:
  - `string`←`pend`, `owner`←`pend_id`, `update`←1.
  - `hold_cnt`←`HOLD_FRAMES`, go to HOLD.
- HOLD: `req` is ignored. On each `frame_start`, `hold_cnt` decrements. On `frame_start` with `hold_cnt`==1, go to IDLE and set `idle_cnt`←0.
- IDLE with no `req`:
  - Each `frame_start` increments `idle_cnt`, saturating at 255.
  - If `IDLE_FRAMES`≠0, `frame_start` is high, `idle_cnt`==`IDLE_FRAMES`−1 and `owner`≠3, then `string`←`IDLE_STRING`, `owner`←3, `update`←1, `idle_cnt`←0.
  - If `owner`==3 already, no reload and no `update`.
- Simultaneous events:
  - `req` and `frame_start` together in IDLE: the grant wins; there is no idle increment and no banner load that cycle.
  - `frame_start` in the same cycle a grant enters WAIT_FRAME: that pulse was sampled in IDLE, so the commit waits for the next `frame_start`.
  - Several `req` bits set: exactly one ack, chosen by the `rr` order.
- Requester protocol: after seeing `ack[i]`, the source must drop `req[i]` the following cycle. Holding it longer is safe, because `req` is ignored outside IDLE; it re-requests only once the scheduler returns to IDLE.
- `msg_i` is sampled only in the grant cycle; later changes do not affect `pend`.
- `rst` (including mid-operation), next edge:
  - state = IDLE, `string`=`IDLE_STRING`, `owner`=3.
  - `ack`=0, `update`=0, `busy`=0.
  - `rr`=0, `hold_cnt`=0, `idle_cnt`=0, `pend`=0, `pend_id`=0.
  - An uncommitted `pend` is discarded without re-ack.

## Timing
- Request to ack: `req` high in IDLE at edge N → `ack` high during cycle N+1 only; `busy` high from cycle N+1.
- Commit: `string`, `owner` and `update` change at the edge that samples `frame_start` in WAIT_FRAME. They are valid in the following cycle, i.e. inside vertical blank.
- Display duration:
  - Committed at frame k, HOLD exits at frame k+`HOLD_FRAMES`.
  - The earliest next commit is frame k+`HOLD_FRAMES`+1, so the minimum visible time is `HOLD_FRAMES`+1 frames.
- Banner: loaded at the `IDLE_FRAMES`-th `frame_start` sampled in IDLE without a grant.
- `string` never changes outside a `frame_start` edge, except at reset.

## Test plan
- Reset: assert `rst` for 2 cycles → `string`="ORGAN READY  ", `owner`=3, `ack`=0, `busy`=0, `update`=0.
- Single request: `req`=001, `msg_0`="C4 VOL 08    " in IDLE → `ack`=001 for exactly 1 cycle. `string` unchanged until the next `frame_start`, then `string`="C4 VOL 08    ", `owner`=0, one `update` pulse. `busy` falls exactly `HOLD_FRAMES` frames later.
- Round-robin: all three `req` held high continuously with `HOLD_FRAMES`=2 → owners committed in order 0, 1, 2, 0; each commit is spaced 3 frames apart.
- Simultaneous: `req`=010 and `frame_start` in the same cycle in IDLE → `ack`=010, no banner load, commit on the next `frame_start`. Also, `msg_1` changed after ack → the committed string equals the value sampled at grant.
- Idle timeout: `IDLE_FRAMES`=4, `owner`=2, no requests → on the 4th `frame_start`, `string`=banner, `owner`=3, one `update`. 10 further frames produce no `update`. With `IDLE_FRAMES`=0, no banner load ever occurs.
- Reset mid-operation: `rst` in WAIT_FRAME holding `pend`="A4 VOL 10    " → the next `frame_start` produces no commit. `string`=banner, `owner`=3; a fresh `req`=100 is acked 1 cycle after `rst` deasserts, with `rr`=0 order.
